// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared constants, opcodes and fetch FSM state encoding.
package instr_fetch_pkg;
    localparam int          XLEN_DEF  = 32;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    localparam logic [6:0]  OP_R      = 7'b0110011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction memory read bus (req/ready handshake).
interface instr_fetch_if import instr_fetch_pkg::*; #(parameter int XLEN = XLEN_DEF);
    logic            req;
    logic [XLEN-1:0] addr;
    logic            ready;
    logic [31:0]     rdata;
    modport master(output req, addr, input ready, rdata);
    modport slave(input req, addr, output ready, rdata);
endinterface

// File: rtl/instr_fetch_pc_next_sel.sv
// pc_next_sel: next-PC priority mux (jump > branch > +4) with alignment force and misalign detect.
module pc_next_sel import instr_fetch_pkg::*; #(parameter int XLEN = XLEN_DEF) (
    input  logic            jump_i,
    input  logic [XLEN-1:0] jump_target_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] next_pc_o,
    output logic            misalign_o
);
    logic [XLEN-1:0] sel;
    always_comb begin
        sel        = jump_i ? jump_target_i : branch_taken_i ? branch_target_i : pc_i + XLEN'(4);
        next_pc_o  = {sel[XLEN-1:2], 2'b00};
        // sequential pc+4 is always aligned, so only a selected redirect can flag
        misalign_o = (jump_i | branch_taken_i) & (sel[1:0] != 2'b00);
    end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch FSM holding PC, fetched instruction and consume count.
module instr_fetch import instr_fetch_pkg::*; #(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              branch_taken_i,
    input  logic [XLEN-1:0]   branch_target_i,
    input  logic              jump_i,
    input  logic [XLEN-1:0]   jump_target_i,
    instr_fetch_if.master     imem,
    output logic [31:0]       instr_o,
    output logic [XLEN-1:0]   instr_pc_o,
    output logic              instr_valid_o,
    output logic [6:0]        opcode_o,
    output logic              misalign_o,
    output logic [XLEN-1:0]   instr_count_o
);
    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, instr_pc_q, count_q, next_pc;
    logic [31:0]     instr_q;
    logic            misalign_q, target_mis, consume, capture;

    pc_next_sel #(.XLEN(XLEN)) u_sel (
        .jump_i         (jump_i),
        .jump_target_i  (jump_target_i),
        .branch_taken_i (branch_taken_i),
        .branch_target_i(branch_target_i),
        .pc_i           (instr_pc_q),
        .next_pc_o      (next_pc),
        .misalign_o     (target_mis)
    );

    assign capture = (state_q == REQ) & imem.ready;
    assign consume = (state_q == VALID) & ~stall_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = REQ;
            REQ:     state_d = imem.ready ? VALID : REQ;
            VALID:   state_d = consume ? REQ : VALID;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            instr_pc_q <= RESET_PC;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            misalign_q <= consume & target_mis;
            if (capture) begin
                instr_q    <= imem.rdata;
                instr_pc_q <= pc_q;
            end
            if (consume) begin
                pc_q    <= next_pc;
                count_q <= count_q + XLEN'(1);
            end
        end
    end

    assign imem.req      = (state_q == REQ);
    assign imem.addr     = pc_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign instr_valid_o = (state_q == VALID);
    assign opcode_o      = instr_q[6:0];
    assign misalign_o    = misalign_q;
    assign instr_count_o = count_q;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed stimulus with a scoreboard queue checked by a valid-edge monitor.
module tb_instr_fetch;
    import instr_fetch_pkg::*;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 0, rst_n = 0, stall = 0, br = 0, jmp = 0, rdy = 0;
    logic [31:0] br_t = '0, jmp_t = '0;
    logic [31:0] instr, instr_pc, count;
    logic        valid, mis, prev_v = 0;
    logic [6:0]  opc;
    int          n_cmp = 0, n_err = 0, cyc = 0, req_cyc = 0, last_cyc = 0;
    exp_t        sb[$];
    exp_t        e;

    instr_fetch_if #(.XLEN(32)) imem();

    instr_fetch #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_i        (stall),
        .branch_taken_i (br),
        .branch_target_i(br_t),
        .jump_i         (jmp),
        .jump_target_i  (jmp_t),
        .imem           (imem),
        .instr_o        (instr),
        .instr_pc_o     (instr_pc),
        .instr_valid_o  (valid),
        .opcode_o       (opc),
        .misalign_o     (mis),
        .instr_count_o  (count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [31:0] word(input logic [31:0] a);
        logic [6:0] op;
        op = a[3:2] == 2'd0 ? OP_R : a[3:2] == 2'd1 ? OP_LOAD : a[3:2] == 2'd2 ? OP_STORE : OP_BRANCH;
        return {a[26:2] ^ 25'h0ABCDE1, op};
    endfunction

    assign imem.ready = rdy;
    assign imem.rdata = word(imem.addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for a request at pc, pushes the expected fetch, inserts wait states, then completes it.
    task automatic fetch_one(input logic [31:0] pc, input int waits);
        int b = 0;
        while (!imem.req && b < 10) begin
            tick();
            b++;
        end
        chk("req_seen", 32'(imem.req), 32'd1);
        if (!imem.req) return;
        req_cyc = cyc;
        chk("imem_addr", imem.addr, pc);
        sb.push_back('{pc, word(pc)});
        for (int i = 0; i < waits; i++) begin
            tick();
            chk("wait_addr", imem.addr, pc);
            chk("wait_valid", 32'(valid), 32'd0);
        end
        rdy = 1;
        tick();
        rdy = 0;
        chk("valid_after_ready", 32'(valid), 32'd1);
    endtask

    always @(negedge clk) begin
        if (valid && !prev_v) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_empty: valid rose with pc %h, no expected entry", instr_pc);
            end else begin
                e = sb.pop_front();
                chk("sb_pc", instr_pc, e.pc);
                chk("sb_instr", instr, e.instr);
                chk("sb_opcode", 32'(opc), 32'(e.instr[6:0]));
            end
        end
        prev_v = valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_instr", instr, NOP_INSTR);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_req", 32'(imem.req), 32'd0);
        chk("rst_count", count, 32'd0);
        chk("rst_mis", 32'(mis), 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        rst_n = 1;
        fetch_one(32'h0, 0);
        tick();
        last_cyc = req_cyc;
        fetch_one(32'h4, 0);
        chk("addr_spacing", 32'(req_cyc - last_cyc), 32'd2);
        last_cyc = req_cyc;
        tick();
        fetch_one(32'h8, 0);
        chk("addr_spacing", 32'(req_cyc - last_cyc), 32'd2);
        tick();
        chk("count_after_3", count, 32'd3);
        fetch_one(32'hC, 3);
        stall = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", 32'(valid), 32'd1);
            chk("stall_instr_pc", instr_pc, 32'hC);
            chk("stall_instr", instr, word(32'hC));
            chk("stall_opcode", 32'(opc), 32'(OP_BRANCH));
            chk("stall_req", 32'(imem.req), 32'd0);
            chk("stall_count", count, 32'd3);
        end
        stall = 0;
        br = 1;
        br_t = 32'h40;
        tick();
        br = 0;
        chk("count_after_branch", count, 32'd4);
        fetch_one(32'h40, 0);
        jmp = 1;
        jmp_t = 32'h80;
        br = 1;
        br_t = 32'h40;
        tick();
        jmp = 0;
        br = 0;
        chk("mis_aligned_jump", 32'(mis), 32'd0);
        fetch_one(32'h80, 0);
        chk("mis_before", 32'(mis), 32'd0);
        jmp = 1;
        jmp_t = 32'h103;
        tick();
        jmp = 0;
        chk("mis_pulse", 32'(mis), 32'd1);
        chk("mis_addr", imem.addr, 32'h100);
        br = 1;
        br_t = 32'h204;
        tick();
        chk("mis_clear", 32'(mis), 32'd0);
        chk("redirect_ignored_in_req", imem.addr, 32'h100);
        br = 0;
        fetch_one(32'h100, 0);
        tick();
        chk("count_after_7", count, 32'd7);
        chk("seq_addr", imem.addr, 32'h104);
        #2 rst_n = 0;
        #1;
        chk("midreq_rst_req", 32'(imem.req), 32'd0);
        chk("midreq_rst_valid", 32'(valid), 32'd0);
        chk("midreq_rst_instr", instr, NOP_INSTR);
        chk("midreq_rst_count", count, 32'd0);
        chk("midreq_rst_instr_pc", instr_pc, 32'd0);
        @(posedge clk);
        #1 rst_n = 1;
        fetch_one(32'h0, 0);
        tick();
        tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
